// File: rtl/fp_pkg.sv
// Shared definitions for the float decomposition pipeline: exponent/fraction
// MSB derivation from the total float width and the fclass one-hot bit indices.
package fp_pkg;

  localparam int FCLASS_W = 10;

  // Bit positions within the one-hot fclass output.
  typedef enum logic [3:0] {
    FC_NINF  = 4'd0,
    FC_NNORM = 4'd1,
    FC_NSUB  = 4'd2,
    FC_NZERO = 4'd3,
    FC_PZERO = 4'd4,
    FC_PSUB  = 4'd5,
    FC_PNORM = 4'd6,
    FC_PINF  = 4'd7,
    FC_SNAN  = 4'd8,
    FC_QNAN  = 4'd9
  } fclass_idx_e;

  // Exponent MSB index for a given total width; unknown widths fall back to a
  // 16-bit style layout.
  function automatic int fp_emsb(input int wid);
    case (wid)
      128, 96, 80:         return 14;
      64, 52, 48, 44, 42:  return 10;
      40:                  return 9;
      32:                  return 7;
      24:                  return 6;
      default:             return 4;
    endcase
  endfunction

  // Stored-mantissa MSB index for a given total width.
  function automatic int fp_fmsb(input int wid);
    case (wid)
      128:     return 111;
      96:      return 79;
      80:      return 63;
      64:      return 51;
      52:      return 39;
      48:      return 35;
      44:      return 31;
      42:      return 29;
      40:      return 28;
      32:      return 22;
      24:      return 15;
      default: return 9;
    endcase
  endfunction

  function automatic logic [FCLASS_W-1:0] fclass_onehot(input fclass_idx_e c);
    return FCLASS_W'(1) << c;
  endfunction

endpackage

// File: rtl/fp_cntlz.sv
// Combinational leading-zero counter; an all-zero input yields WIDTH.
module fp_cntlz #(
  parameter int WIDTH = 23
) (
  input  logic [WIDTH-1:0]               a_i,
  output logic [$clog2(WIDTH+1)-1:0]     cnt_o
);

  localparam int CW = $clog2(WIDTH + 1);

  // Ascending scan: the last hit is the most significant set bit.
  always_comb begin
    cnt_o = CW'(WIDTH);
    for (int unsigned b = 0; b < WIDTH; b++) begin
      if (a_i[b]) cnt_o = CW'(WIDTH - 1 - b);
    end
  end

endmodule

// File: rtl/fp_decomp_pipe.sv
// Two-stage float decomposition pipeline: stage 1 splits fields and derives
// flags, stage 2 classifies and (optionally) normalizes. Stage 2 registers
// drive the outputs directly.
// Optional feature: define FP_DECOMP_NORM_EN to add the normalized outputs
// (nfract, nexp, lzc) and the leading-zero counter.
module fp_decomp_pipe
  import fp_pkg::*;
#(
  parameter  int WID  = 32,
  localparam int EMSB = fp_emsb(WID),
  localparam int FMSB = fp_fmsb(WID),
  localparam int LZW  = $clog2(FMSB + 2)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WID-1:0]       i,
  input  logic                 i_valid,
  output logic                 i_ready,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic                 sgn,
  output logic [EMSB:0]        exp,
  output logic [FMSB:0]        man,
  output logic [FMSB+1:0]      fract,
  output logic                 xz,
  output logic                 mz,
  output logic                 vz,
  output logic                 inf,
  output logic                 xinf,
  output logic                 qnan,
  output logic                 snan,
  output logic                 nan,
  output logic [FCLASS_W-1:0]  fclass
`ifdef FP_DECOMP_NORM_EN
  ,
  output logic [FMSB+1:0]      nfract,
  output logic signed [EMSB+1:0] nexp,
  output logic [LZW-1:0]       lzc
`endif
);

  localparam int SB = EMSB + FMSB + 2;

  // Handshake
  logic s1_v_q, s2_v_q;
  logic s1_adv, s2_adv, acc;

  // Stage 1 state
  logic            s1_sgn_d, s1_sgn_q;
  logic [EMSB:0]   s1_exp_d, s1_exp_q;
  logic [FMSB:0]   s1_man_d, s1_man_q;
  logic            s1_xz_d, s1_xz_q, s1_mz_d, s1_mz_q, s1_vz_d, s1_vz_q;
  logic            s1_inf_d, s1_inf_q, s1_xinf_d, s1_xinf_q;
  logic            s1_qnan_d, s1_qnan_q, s1_snan_d, s1_snan_q, s1_nan_d, s1_nan_q;

  // Stage 2 state
  logic            s2_sgn_q;
  logic [EMSB:0]   s2_exp_q;
  logic [FMSB:0]   s2_man_q;
  logic [FMSB+1:0] s2_fract_d, s2_fract_q;
  logic            s2_xz_q, s2_mz_q, s2_vz_q, s2_inf_q, s2_xinf_q;
  logic            s2_qnan_q, s2_snan_q, s2_nan_q;
  logic [FCLASS_W-1:0] s2_fclass_d, s2_fclass_q;
  fclass_idx_e     cls_d;

  // A stage advances when its successor is empty or draining this cycle.
  assign s2_adv  = !s2_v_q || o_ready;
  assign s1_adv  = !s1_v_q || s2_adv;
  assign i_ready = s1_adv;
  assign acc     = i_valid && i_ready;

  // Stage 1 field split and flag derivation from the raw operand.
  always_comb begin
    s1_sgn_d  = i[SB];
    s1_exp_d  = i[FMSB+1 +: EMSB+1];
    s1_man_d  = i[FMSB:0];
    s1_xz_d   = ~|s1_exp_d;
    s1_mz_d   = ~|s1_man_d;
    s1_vz_d   = s1_xz_d && s1_mz_d;
    s1_xinf_d = &s1_exp_d;
    s1_inf_d  = s1_xinf_d && s1_mz_d;
    s1_nan_d  = s1_xinf_d && !s1_mz_d;
    s1_qnan_d = s1_xinf_d && s1_man_d[FMSB];
    s1_snan_d = s1_nan_d && !s1_man_d[FMSB];
  end

  // Stage 1 registers; data only loads on an accepted operand.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q    <= 1'b0;
      s1_sgn_q  <= 1'b0;
      s1_exp_q  <= '0;
      s1_man_q  <= '0;
      s1_xz_q   <= 1'b0;
      s1_mz_q   <= 1'b0;
      s1_vz_q   <= 1'b0;
      s1_inf_q  <= 1'b0;
      s1_xinf_q <= 1'b0;
      s1_qnan_q <= 1'b0;
      s1_snan_q <= 1'b0;
      s1_nan_q  <= 1'b0;
    end else begin
      if (s1_adv) s1_v_q <= acc;
      if (acc) begin
        s1_sgn_q  <= s1_sgn_d;
        s1_exp_q  <= s1_exp_d;
        s1_man_q  <= s1_man_d;
        s1_xz_q   <= s1_xz_d;
        s1_mz_q   <= s1_mz_d;
        s1_vz_q   <= s1_vz_d;
        s1_inf_q  <= s1_inf_d;
        s1_xinf_q <= s1_xinf_d;
        s1_qnan_q <= s1_qnan_d;
        s1_snan_q <= s1_snan_d;
        s1_nan_q  <= s1_nan_d;
      end
    end
  end

  // Stage 2 classification; NaN and infinity take precedence over sign-based classes.
  always_comb begin
    cls_d = FC_PNORM;
    if (s1_nan_q)      cls_d = s1_man_q[FMSB] ? FC_QNAN : FC_SNAN;
    else if (s1_inf_q) cls_d = s1_sgn_q ? FC_NINF  : FC_PINF;
    else if (s1_vz_q)  cls_d = s1_sgn_q ? FC_NZERO : FC_PZERO;
    else if (s1_xz_q)  cls_d = s1_sgn_q ? FC_NSUB  : FC_PSUB;
    else               cls_d = s1_sgn_q ? FC_NNORM : FC_PNORM;
    s2_fclass_d = fclass_onehot(cls_d);
    s2_fract_d  = {!s1_xz_q, s1_man_q};
  end

  // Stage 2 / output registers; contents hold while stalled or empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v_q      <= 1'b0;
      s2_sgn_q    <= 1'b0;
      s2_exp_q    <= '0;
      s2_man_q    <= '0;
      s2_fract_q  <= '0;
      s2_xz_q     <= 1'b0;
      s2_mz_q     <= 1'b0;
      s2_vz_q     <= 1'b0;
      s2_inf_q    <= 1'b0;
      s2_xinf_q   <= 1'b0;
      s2_qnan_q   <= 1'b0;
      s2_snan_q   <= 1'b0;
      s2_nan_q    <= 1'b0;
      s2_fclass_q <= '0;
    end else begin
      if (s2_adv) s2_v_q <= s1_v_q;
      if (s2_adv && s1_v_q) begin
        s2_sgn_q    <= s1_sgn_q;
        s2_exp_q    <= s1_exp_q;
        s2_man_q    <= s1_man_q;
        s2_fract_q  <= s2_fract_d;
        s2_xz_q     <= s1_xz_q;
        s2_mz_q     <= s1_mz_q;
        s2_vz_q     <= s1_vz_q;
        s2_inf_q    <= s1_inf_q;
        s2_xinf_q   <= s1_xinf_q;
        s2_qnan_q   <= s1_qnan_q;
        s2_snan_q   <= s1_snan_q;
        s2_nan_q    <= s1_nan_q;
        s2_fclass_q <= s2_fclass_d;
      end
    end
  end

  assign o_valid = s2_v_q;
  assign sgn     = s2_sgn_q;
  assign exp     = s2_exp_q;
  assign man     = s2_man_q;
  assign fract   = s2_fract_q;
  assign xz      = s2_xz_q;
  assign mz      = s2_mz_q;
  assign vz      = s2_vz_q;
  assign inf     = s2_inf_q;
  assign xinf    = s2_xinf_q;
  assign qnan    = s2_qnan_q;
  assign snan    = s2_snan_q;
  assign nan     = s2_nan_q;
  assign fclass  = s2_fclass_q;

`ifdef FP_DECOMP_NORM_EN
  localparam int EXW = EMSB + 2;

  logic [LZW-1:0]        lz_raw, lz_p1;
  logic [FMSB+1:0]       nfract_d, nfract_q;
  logic signed [EMSB+1:0] nexp_d, nexp_q;
  logic [LZW-1:0]        lzc_d, lzc_q;

  fp_cntlz #(
    .WIDTH (FMSB + 1)
  ) u_cntlz (
    .a_i   (s1_man_q),
    .cnt_o (lz_raw)
  );

  // Subnormals shift past the leading zeros and the implicit position so the
  // first set bit lands in the hidden-bit slot.
  always_comb begin
    lz_p1    = lz_raw + LZW'(1);
    nfract_d = s2_fract_d;
    nexp_d   = $signed({1'b0, s1_exp_q});
    lzc_d    = '0;
    if (s1_vz_q) begin
      nfract_d = '0;
      nexp_d   = '0;
      lzc_d    = LZW'(FMSB + 1);
    end else if (s1_xz_q) begin
      nfract_d = s2_fract_d << lz_p1;
      nexp_d   = -$signed(EXW'(lz_raw));
      lzc_d    = lz_raw;
    end
  end

  // Normalized result registers, loaded alongside the rest of stage 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nfract_q <= '0;
      nexp_q   <= '0;
      lzc_q    <= '0;
    end else if (s2_adv && s1_v_q) begin
      nfract_q <= nfract_d;
      nexp_q   <= nexp_d;
      lzc_q    <= lzc_d;
    end
  end

  assign nfract = nfract_q;
  assign nexp   = nexp_q;
  assign lzc    = lzc_q;
`endif

endmodule

// File: tb/tb_fp_decomp_pipe.sv
// Self-checking bench for fp_decomp_pipe at WID=32. Honours FP_DECOMP_NORM_EN.
module tb_fp_decomp_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] i;
  logic        i_valid, i_ready, o_valid, o_ready;
  logic        sgn;
  logic [7:0]  exp;
  logic [22:0] man;
  logic [23:0] fract;
  logic        xz, mz, vz, inf, xinf, qnan, snan, nan;
  logic [9:0]  fclass;
`ifdef FP_DECOMP_NORM_EN
  logic [23:0] nfract;
  logic signed [8:0] nexp;
  logic [4:0]  lzc;
`endif

  int total = 0;
  int bad   = 0;
  logic [127:0] sb[$];

  fp_decomp_pipe #(.WID(32)) dut (
    .clk(clk), .rst_n(rst_n), .i(i), .i_valid(i_valid), .i_ready(i_ready),
    .o_valid(o_valid), .o_ready(o_ready), .sgn(sgn), .exp(exp), .man(man),
    .fract(fract), .xz(xz), .mz(mz), .vz(vz), .inf(inf), .xinf(xinf),
    .qnan(qnan), .snan(snan), .nan(nan), .fclass(fclass)
`ifdef FP_DECOMP_NORM_EN
    , .nfract(nfract), .nexp(nexp), .lzc(lzc)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Reference: IEEE single-precision classification from field arithmetic.
  function automatic logic [127:0] model(input logic [31:0] x);
    int unsigned s, e, m, k, lz;
    logic [23:0] fr, nf;
    logic [8:0]  ne;
    logic [127:0] r;
    s  = x >> 31;
    e  = (x >> 23) & 255;
    m  = x & 32'h7F_FFFF;
    fr = (e != 0) ? 24'(m + (1 << 23)) : 24'(m);
    if (e == 255)    k = (m == 0) ? (s ? 0 : 7) : ((m >= (1 << 22)) ? 9 : 8);
    else if (e == 0) k = (m == 0) ? (s ? 3 : 4) : (s ? 2 : 5);
    else             k = s ? 1 : 6;
    r = '0;
    r[73:0] = {1'(s), 8'(e), 23'(m), fr,
               e == 0, m == 0, (e == 0 && m == 0), (e == 255 && m == 0), e == 255,
               (e == 255 && m >= (1 << 22)), (e == 255 && m != 0 && m < (1 << 22)),
               (e == 255 && m != 0), 10'd1 << k};
    if (e == 0 && m == 0) begin
      nf = '0; ne = '0; lz = 23;
    end else if (e == 0) begin
      lz = 0;
      while (m < (1 << (22 - lz))) lz++;
      nf = 24'(m << (lz + 1));
      ne = 9'(512 - lz);
    end else begin
      nf = fr; ne = 9'(e); lz = 0;
    end
`ifdef FP_DECOMP_NORM_EN
    r[111:74] = {nf, ne, 5'(lz)};
`endif
    return r;
  endfunction

  function automatic logic [127:0] got();
    logic [127:0] r;
    r = '0;
    r[73:0] = {sgn, exp, man, fract, xz, mz, vz, inf, xinf, qnan, snan, nan, fclass};
`ifdef FP_DECOMP_NORM_EN
    r[111:74] = {nfract, nexp, lzc};
`endif
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One clock: drive at negedge, score the handshakes that the next posedge commits.
  task automatic cyc(input logic vld, input logic [31:0] d, input logic ord,
                     output logic accd, output logic [127:0] snap, output logic ov);
    @(negedge clk);
    i_valid = vld; i = d; o_ready = ord;
    #1;
    snap = got();
    ov   = o_valid;
    accd = vld && i_ready;
    if (o_valid && o_ready) begin
      if (sb.size() == 0) check("spurious_out", {127'b0, o_valid}, 128'd0);
      else begin
        check("result", snap, sb.pop_front());
        check("onehot", $countones(fclass), 1);
      end
    end
    if (accd) sb.push_back(model(d));
    @(posedge clk);
  endtask

  task automatic run_one(input logic [31:0] x);
    logic a, ov; logic [127:0] s;
    cyc(1'b1, x, 1'b1, a, s, ov);
    check("accept", a, 1);
    cyc(1'b0, 32'h0, 1'b1, a, s, ov);
    check("lat1_ovalid", ov, 0);
    cyc(1'b0, 32'h0, 1'b1, a, s, ov);
    check("lat2_ovalid", ov, 1);
    #1;
  endtask

  initial begin
    logic a, ov;
    logic [127:0] s, snap0;
    logic [31:0] op[4];
    logic [31:0] r;
    int idx;

    // Reset state
    rst_n = 1'b0; i_valid = 1'b0; o_ready = 1'b0; i = '0;
    #1;
    check("rst_ovalid", o_valid, 0);
    check("rst_iready", i_ready, 1);
    check("rst_fclass", fclass, 0);
    check("rst_data", got(), 128'd0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    #1;
    check("post_rst_iready", i_ready, 1);

    // Directed values
    run_one(32'h3F80_0000);
    check("one_exp", exp, 8'h7F);
    check("one_fract", fract, 24'h80_0000);
    check("one_fclass", fclass, 10'h040);
    run_one(32'hFF80_0000);
    check("ninf_inf", inf, 1);
    check("ninf_xinf", xinf, 1);
    check("ninf_fclass", fclass, 10'h001);
    run_one(32'h7FC0_0000);
    check("qnan_flag", qnan, 1);
    check("qnan_fclass", fclass, 10'h200);
    run_one(32'h7F80_0001);
    check("snan_flag", snan, 1);
    check("snan_fclass", fclass, 10'h100);
    run_one(32'h0000_0001);
    check("sub_xz", xz, 1);
    check("sub_fclass", fclass, 10'h020);
`ifdef FP_DECOMP_NORM_EN
    check("sub_lzc", lzc, 22);
    check("sub_nfract", nfract, 24'h80_0000);
    check("sub_nexp", nexp, 9'h1EA);
`endif
    run_one(32'h8000_0000);
    check("nzero_vz", vz, 1);
    check("nzero_fclass", fclass, 10'h008);
`ifdef FP_DECOMP_NORM_EN
    check("nzero_lzc", lzc, 23);
`endif

    // Back-to-back with free consumer: one accept every cycle
    for (int k = 0; k < 6; k++) begin
      cyc(1'b1, $urandom, 1'b1, a, s, ov);
      check("no_bubble", a, 1);
    end
    for (int k = 0; k < 3; k++) cyc(1'b0, 32'h0, 1'b1, a, s, ov);
    check("b2b_drained", sb.size(), 0);

    // Stall: consumer blocked for several cycles
    op[0] = 32'h4049_0FDB; op[1] = 32'h8000_0001; op[2] = 32'hFF80_0000; op[3] = 32'h7FC0_1234;
    idx = 0;
    snap0 = '0;
    for (int c = 0; c < 5; c++) begin
      cyc(1'b1, op[idx], 1'b0, a, s, ov);
      if (a) idx++;
      if (c >= 2) begin
        check("stall_iready_low", a, 0);
        check("stall_ovalid", ov, 1);
      end
      if (c == 2) snap0 = s;
      if (c > 2) check("stall_hold", s, snap0);
    end
    check("stall_accepts", idx, 2);
    for (int c = 0; c < 20; c++) begin
      if (idx >= 4 && sb.size() == 0) break;
      cyc(idx < 4, (idx < 4) ? op[idx] : 32'h0, 1'b1, a, s, ov);
      if (a) idx++;
    end
    check("stall_all_in", idx, 4);
    check("stall_all_out", sb.size(), 0);

    // Reset with two operands in flight
    cyc(1'b1, 32'hC049_0FDB, 1'b0, a, s, ov);
    cyc(1'b1, 32'h3F80_0000, 1'b0, a, s, ov);
    @(negedge clk);
    i_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_ovalid", o_valid, 0);
    check("midrst_data", got(), 128'd0);
    check("midrst_iready", i_ready, 1);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, 32'h0, 1'b1, a, s, ov);
      check("no_stale", ov, 0);
    end

    // Randomized traffic with random stalls
    for (int c = 0; c < 4000; c++) begin
      r = $urandom;
      case ($urandom % 5)
        0: r[30:23] = 8'h00;
        1: r[30:23] = 8'hFF;
        2: r[22:0]  = '0;
        3: r[30:0]  = '0;
        default: ;
      endcase
      cyc(($urandom % 4) != 0, r, ($urandom % 3) != 0, a, s, ov);
    end
    for (int c = 0; c < 20; c++) begin
      if (sb.size() == 0) break;
      cyc(1'b0, 32'h0, 1'b1, a, s, ov);
    end
    check("rand_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
